// File: rtl/nist_sp800_22_pkg.sv
// Shared types and sizing helpers for the NIST SP 800-22 health-test blocks.
// Default constants target alpha = 0.01 for 128-bit sequences split into 8-bit blocks.
package nist_sp800_22_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL,
        REPORT
    } nist_state_t;

    localparam int unsigned NIST_DEF_N_BITS      = 128;
    localparam int unsigned NIST_DEF_M_BITS      = 8;
    localparam int unsigned NIST_DEF_FREQ_THR    = 29;
    localparam int unsigned NIST_DEF_BLK_SSQ_MAX = 256;

    // Signed running sum S spans -N..+N
    function automatic int unsigned s_width(input int unsigned n_bits);
        return $clog2(n_bits) + 2;
    endfunction

    // Per-block ones count spans 0..M
    function automatic int unsigned c_width(input int unsigned m_bits);
        return $clog2(m_bits) + 1;
    endfunction

    // Worst case SSQ is (N/M) blocks of M^2, i.e. N*M
    function automatic int unsigned ssq_width(input int unsigned n_bits, input int unsigned m_bits);
        return $clog2(n_bits * m_bits + 1);
    endfunction

endpackage

// File: rtl/nist_blk_sumsq.sv
// Block-frequency accumulator: per-block ones count, d = 2c - M, running sum of d^2.
// Latency: a block's square is folded in the cycle after its last bit; ssq_tot already includes it.
// Backpressure: none; the caller gates accept with its own valid/ready handshake.
module nist_blk_sumsq
    import nist_sp800_22_pkg::*;
#(
    parameter int unsigned N_BITS = NIST_DEF_N_BITS,
    parameter int unsigned M_BITS = NIST_DEF_M_BITS,
    parameter int unsigned SSQ_W  = ssq_width(N_BITS, M_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             finish,
    input  logic             bit_in,
    output logic [SSQ_W-1:0] ssq_tot
);

    localparam int unsigned CW = c_width(M_BITS);
    localparam int unsigned BW = $clog2(M_BITS);
    localparam int unsigned DW = CW + 2;
    localparam int unsigned PW = 2 * DW;
    localparam logic [BW-1:0]        BIDX_LAST = BW'(M_BITS - 1);
    localparam logic signed [DW-1:0] M_S       = DW'(M_BITS);

    logic [CW-1:0]        c_q;
    logic [CW-1:0]        c_fin;
    logic [BW-1:0]        bidx_q;
    logic signed [DW-1:0] d_q;
    logic signed [DW-1:0] d_n;
    logic                 d_vld_q;
    logic signed [PW-1:0] d_sq;
    logic [SSQ_W-1:0]     ssq_q;

    assign c_fin   = c_q + CW'(bit_in);
    assign d_n     = $signed({1'b0, c_fin, 1'b0}) - M_S;
    assign d_sq    = d_q * d_q;
    assign ssq_tot = ssq_q + (d_vld_q ? SSQ_W'($unsigned(d_sq)) : '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            c_q     <= '0;
            bidx_q  <= '0;
            d_q     <= '0;
            d_vld_q <= 1'b0;
            ssq_q   <= '0;
        end else begin
            ssq_q   <= ssq_tot;
            d_vld_q <= 1'b0;
            if (finish) begin
                // Close out the sequence so a stray partial block never leaks forward
                c_q    <= '0;
                bidx_q <= '0;
            end else if (accept) begin
                if (bidx_q == BIDX_LAST) begin
                    d_q     <= d_n;
                    d_vld_q <= 1'b1;
                    c_q     <= '0;
                    bidx_q  <= '0;
                end else begin
                    c_q    <= c_fin;
                    bidx_q <= bidx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nist_freq_blk_tester.sv
// Frequency (monobit) and Block Frequency health tests over successive N_BITS-bit RNG sequences.
// Latency: last bit accepted in cycle t -> seq_done/results in t+2; next sequence accepts from t+3.
// Backpressure: bit_ready only in COLLECT with en high; bits are held off during EVAL/REPORT.
module nist_freq_blk_tester
    import nist_sp800_22_pkg::*;
#(
    parameter int unsigned N_BITS      = NIST_DEF_N_BITS,
    parameter int unsigned M_BITS      = NIST_DEF_M_BITS,
    parameter int unsigned FREQ_THR    = NIST_DEF_FREQ_THR,
    parameter int unsigned BLK_SSQ_MAX = NIST_DEF_BLK_SSQ_MAX,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             clr_err,
    output logic             seq_done,
    output logic             freq_fail,
    output logic             blk_fail,
    output logic             err_freq,
    output logic             err_blk,
    output logic [CNT_W-1:0] seq_count
);

    localparam int unsigned SW    = s_width(N_BITS);
    localparam int unsigned IW    = $clog2(N_BITS);
    localparam int unsigned SSQ_W = ssq_width(N_BITS, M_BITS);
    localparam logic [IW-1:0]        IDX_LAST = IW'(N_BITS - 1);
    localparam logic signed [SW-1:0] S_ONE    = SW'(1);

    nist_state_t          state_q;
    nist_state_t          state_n;
    logic                 accept;
    logic signed [SW-1:0] s_q;
    logic [SW-1:0]        s_abs;
    logic [IW-1:0]        idx_q;
    logic [SSQ_W-1:0]     ssq_tot;
    logic                 freq_over;
    logic                 blk_over;
    logic                 acc_clear;

    assign accept    = bit_valid & bit_ready;
    assign acc_clear = (state_q == IDLE) || (state_q == REPORT);
    assign s_abs     = s_q[SW-1] ? $unsigned(-s_q) : $unsigned(s_q);
    assign freq_over = 32'(s_abs) > FREQ_THR;
    assign blk_over  = 32'(ssq_tot) > BLK_SSQ_MAX;

    nist_blk_sumsq #(
        .N_BITS (N_BITS),
        .M_BITS (M_BITS),
        .SSQ_W  (SSQ_W)
    ) u_blk_sumsq (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .accept  (accept),
        .finish  (state_q == EVAL),
        .bit_in  (bit_in),
        .ssq_tot (ssq_tot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        bit_ready = 1'b0;
        seq_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_n = COLLECT;
            end
            COLLECT: begin
                bit_ready = en;
                if (!en) begin
                    state_n = IDLE;
                end else if (bit_valid && idx_q == IDX_LAST) begin
                    state_n = EVAL;
                end
            end
            EVAL: begin
                state_n = en ? REPORT : IDLE;
            end
            REPORT: begin
                seq_done = 1'b1;
                state_n  = en ? COLLECT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            idx_q     <= '0;
            freq_fail <= 1'b0;
            blk_fail  <= 1'b0;
            err_freq  <= 1'b0;
            err_blk   <= 1'b0;
            seq_count <= '0;
        end else begin
            if (acc_clear) begin
                s_q   <= '0;
                idx_q <= '0;
            end else if (accept) begin
                s_q   <= bit_in ? s_q + S_ONE : s_q - S_ONE;
                idx_q <= idx_q + 1'b1;
            end
            // Results land on the EVAL->REPORT edge so they are valid alongside seq_done
            if (state_q == EVAL && en) begin
                freq_fail <= freq_over;
                blk_fail  <= blk_over;
                seq_count <= seq_count + 1'b1;
            end
            err_freq <= (err_freq & ~clr_err) | ((state_q == REPORT) & freq_fail);
            err_blk  <= (err_blk  & ~clr_err) | ((state_q == REPORT) & blk_fail);
        end
    end

endmodule

// File: tb/tb_nist_freq_blk_tester.sv
// Directed bench for nist_freq_blk_tester at default parameters (N=128, M=8, THR=29, SSQ_MAX=256).
module tb_nist_freq_blk_tester;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        clr_err;
    logic        seq_done;
    logic        freq_fail;
    logic        blk_fail;
    logic        err_freq;
    logic        err_blk;
    logic [15:0] seq_count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    nist_freq_blk_tester dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .clr_err   (clr_err),
        .seq_done  (seq_done),
        .freq_fail (freq_fail),
        .blk_fail  (blk_fail),
        .err_freq  (err_freq),
        .err_blk   (err_blk),
        .seq_count (seq_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seq_done) done_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one bit from a negedge; it is taken at the next posedge once bit_ready is seen
    task automatic send_bit(input logic b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            bit_valid = 1'b0;
        end
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        n = 0;
        while (!bit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bit_ready) chk_eq("ready_timeout", 32'(bit_ready), 32'd1);
    endtask

    task automatic run_seq(input string tag, input logic [127:0] v, input int maxgap,
                           input logic exp_ff, input logic exp_bf, input int exp_cnt,
                           input logic chk_err, input logic clr_rep,
                           input logic exp_ef, input logic exp_eb);
        for (int i = 0; i < 128; i++) begin
            send_bit(v[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        chk_eq({tag, "_done_t1"}, 32'(seq_done), 32'd0);
        @(negedge clk);
        chk_eq({tag, "_done_t2"}, 32'(seq_done), 32'd1);
        chk_eq({tag, "_freq_fail"}, 32'(freq_fail), 32'(exp_ff));
        chk_eq({tag, "_blk_fail"}, 32'(blk_fail), 32'(exp_bf));
        chk_eq({tag, "_seq_count"}, 32'(seq_count), 32'(exp_cnt));
        if (clr_rep) clr_err = 1'b1;
        if (chk_err) begin
            @(negedge clk);
            clr_err = 1'b0;
            chk_eq({tag, "_err_freq"}, 32'(err_freq), 32'(exp_ef));
            chk_eq({tag, "_err_blk"}, 32'(err_blk), 32'(exp_eb));
        end
    endtask

    logic [127:0] v_zero, v_alt, v_half, v_78, v_79, v_256, v_260;
    int d0;

    initial begin
        // Bit i of each vector is the i-th bit sent; bytes are 8-bit blocks
        v_zero = '0;
        v_alt  = {16{8'hAA}};
        v_half = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        v_78   = {{2{8'h0F}}, {14{8'h1F}}};                                 // S=28, SSQ=56
        v_79   = {8'h0F, {15{8'h1F}}};                                      // S=30, SSQ=60
        v_256  = {8'hFF, {6{8'h3F}}, {6{8'h03}}, {3{8'h0F}}};               // S=8,  SSQ=256
        v_260  = {8'hFF, {6{8'h3F}}, {6{8'h03}}, {2{8'h0F}}, 8'h1F};        // S=10, SSQ=260

        rst = 1'b1; en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_bit_ready", 32'(bit_ready), 32'd0);
        chk_eq("rst_seq_done", 32'(seq_done), 32'd0);
        chk_eq("rst_freq_fail", 32'(freq_fail), 32'd0);
        chk_eq("rst_blk_fail", 32'(blk_fail), 32'd0);
        chk_eq("rst_err_freq", 32'(err_freq), 32'd0);
        chk_eq("rst_err_blk", 32'(err_blk), 32'd0);
        chk_eq("rst_seq_count", 32'(seq_count), 32'd0);

        en = 1'b1;
        run_seq("zeros", v_zero, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b1);

        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk_eq("clr_err_freq", 32'(err_freq), 32'd0);
        chk_eq("clr_err_blk", 32'(err_blk), 32'd0);

        run_seq("alt",   v_alt,  0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_seq("half",  v_half, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("ones78", v_78,  0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("ones79", v_79,  0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("ssq256", v_256, 0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("ssq260", v_260, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Three back-to-back sequences with random gaps in bit_valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_seq("gap_half", v_half, 3, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("gap_78",   v_78,   3, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("gap_79",   v_79,   3, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort by en=0 at bit 70
        for (int i = 0; i < 70; i++) send_bit(v_zero[i], 0);
        d0 = done_cnt;
        @(negedge clk);
        bit_valid = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("abort_bit_ready", 32'(bit_ready), 32'd0);
        chk_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk_eq("abort_seq_count", 32'(seq_count), 32'd3);
        chk_eq("abort_freq_fail", 32'(freq_fail), 32'd1);
        en = 1'b1;
        run_seq("post_abort", v_alt, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Synchronous reset at bit 70
        for (int i = 0; i < 70; i++) send_bit(v_zero[i], 0);
        d0 = done_cnt;
        @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk_eq("midrst_bit_ready", 32'(bit_ready), 32'd0);
        chk_eq("midrst_seq_count", 32'(seq_count), 32'd0);
        chk_eq("midrst_freq_fail", 32'(freq_fail), 32'd0);
        chk_eq("midrst_err_freq", 32'(err_freq), 32'd0);
        run_seq("post_rst", v_alt, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // clr_err during a failing REPORT: the new error wins
        run_seq("clr_at_rep", v_zero, 0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1);

        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk_eq("final_err_freq", 32'(err_freq), 32'd0);
        chk_eq("final_err_blk", 32'(err_blk), 32'd0);
        chk_eq("final_freq_kept", 32'(freq_fail), 32'd1);
        chk_eq("final_blk_kept", 32'(blk_fail), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
